// File: rtl/tsm_share_decoder.sv
// Two-share unmasking endpoint: registers share 1, recombines with share 2 into a
// registered plaintext word, then zeroizes the stored share and output between words.
module tsm_share_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_idx,
  input  logic [WIDTH-1:0] in_share,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD1 = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] share1_reg;

  // in_ready is a registered copy of (state != OUT), so it never depends on out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      share1_reg <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
      in_ready   <= 1'b1;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (!in_idx) begin
              share1_reg <= in_share;
              state      <= HOLD1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        HOLD1: begin
          if (in_valid && in_ready) begin
            if (in_idx) begin
              out_data   <= share1_reg ^ in_share;
              share1_reg <= '0;
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              state      <= OUT;
            end else begin
              share1_reg <= in_share;
              err        <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            word_cnt  <= word_cnt + CNT_W'(1);
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          share1_reg <= '0;
          out_data   <= '0;
          out_valid  <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsm_share_decoder.sv
// Scoreboard bench for tsm_share_decoder: a pairing model predicts plaintext words and
// order errors; a monitor pops and compares on every output handshake.
module tb_tsm_share_decoder;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_idx = 1'b0;
  logic [WIDTH-1:0] in_share = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  tsm_share_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_share(in_share), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [WIDTH-1:0] exp_q[$];
  bit               have_s1 = 0;
  logic [WIDTH-1:0] s1_val = '0;
  int               err_exp = 0;
  int               err_seen = 0;
  int               delivered = 0;
  int               ready_mode = 1; // 0 low, 1 high, 2 random

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always begin
    @(negedge clk);
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // monitor: samples just after the negedge, once inputs for the next posedge are settled
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (err) err_seen++;
      check("in_ready_vs_state", in_ready, !out_valid);
      if (!out_valid) check("out_data_zero_idle", out_data, 0);
      if (out_valid && out_ready) begin
        check("word_cnt_before_hs", word_cnt, delivered % (1 << CNT_W));
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        delivered++;
      end
    end
  end

  task automatic send(input logic idx, input logic [WIDTH-1:0] val);
    int budget = 200;
    bit completes;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    completes = idx && have_s1;
    if (!idx) begin
      if (have_s1) err_exp++;
      s1_val  = val;
      have_s1 = 1;
    end else if (have_s1) begin
      exp_q.push_back(s1_val ^ val);
      have_s1 = 0;
    end else begin
      err_exp++;
    end
    in_valid = 1'b1;
    in_idx   = idx;
    in_share = val;
    @(negedge clk);
    in_valid = 1'b0;
    in_idx   = $urandom_range(0, 1);
    in_share = WIDTH'($urandom);
    if (completes) check("latency_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    int budget = 300;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [CNT_W-1:0] cnt_hold;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;

    // T1: reset in the middle of HOLD1 aborts the word
    send(1'b0, 8'h5A);
    #2 rst = 1'b1;
    have_s1 = 0;
    #1;
    check("t1_out_valid", out_valid, 0);
    check("t1_out_data", out_data, 0);
    check("t1_err", err, 0);
    check("t1_word_cnt", word_cnt, 0);
    check("t1_share1_zero", dut.share1_reg, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_in_ready", in_ready, 1);

    // T2: nominal pair
    ready_mode = 1;
    send(1'b0, 8'hA5);
    send(1'b1, 8'h3C);
    drain();
    check("t2_word_cnt", word_cnt, 1);

    // T3: backpressure holds the word
    ready_mode = 0;
    send(1'b0, 8'hA5);
    send(1'b1, 8'h3C);
    cnt_hold = word_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("t3_out_valid", out_valid, 1);
      check("t3_out_data", out_data, 8'h99);
      check("t3_in_ready", in_ready, 0);
      check("t3_word_cnt", word_cnt, cnt_hold);
    end
    ready_mode = 1;
    drain();
    check("t3_word_cnt_after", word_cnt, 2);

    // T4: share 2 first, then a valid pair
    send(1'b1, 8'hFF);
    @(negedge clk);
    check("t4_no_output", out_valid, 0);
    send(1'b0, 8'h0F);
    send(1'b1, 8'hF0);
    drain();

    // T5: share 1 overwritten
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    send(1'b1, 8'h22);
    drain();
    check("t5_err_count", err_seen, err_exp);

    // T6: wrap the counter, probe zeroization after every word
    ready_mode = 2;
    for (int w = 0; w < 16; w++) begin
      send(1'b0, WIDTH'($urandom));
      send(1'b1, WIDTH'($urandom));
      drain();
      check("t6_share1_zero", dut.share1_reg, 0);
      check("t6_out_data_zero", out_data, 0);
    end
    check("t6_word_cnt", word_cnt, delivered % (1 << CNT_W));

    // random ordering and backpressure
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    check("final_err_count", err_seen, err_exp);
    check("final_word_cnt", word_cnt, delivered % (1 << CNT_W));
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
